// File: rtl/rvc_parcel_aligner.sv
// RV32IC fetch parcel aligner: slices 32-bit fetch words into 16/32-bit instructions,
// stitching 32-bit instructions that straddle a word boundary.
module rvc_parcel_aligner #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_stall,
  input  logic            i_fetch_valid,
  input  logic [31:0]     i_fetch_word,
  output logic            o_fetch_ready,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  output logic            o_is_compressed,
  output logic            o_is_32bit_spanning,
  output logic            o_spanning_wait_for_fetch,
  output logic            o_spanning_in_progress,
  output logic            o_spanning_to_halfword
);

  typedef enum logic [1:0] {StNormal, StSpanWait, StSpanTail} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [15:0]     half_buf_q, half_buf_d;
  logic [31:0]     word_buf_q, word_buf_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            comp_q, comp_d;
  logic            span_q, span_d;
  logic            to_half_q, to_half_d;

  logic        accept;
  logic [15:0] parcel;
  logic [15:0] tail;

  assign o_fetch_ready = !i_stall && (state_q != StSpanTail);
  assign accept        = i_fetch_valid && o_fetch_ready;
  assign parcel        = pc_q[1] ? i_fetch_word[31:16] : i_fetch_word[15:0];
  assign tail          = word_buf_q[31:16];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    half_buf_d = half_buf_q;
    word_buf_d = word_buf_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    comp_d     = comp_q;
    span_d     = span_q;
    to_half_d  = to_half_q;

    if (i_flush) begin
      state_d    = StNormal;
      pc_d       = i_redirect_pc & ~XLEN'(1);
      half_buf_d = '0;
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      comp_d     = 1'b0;
      span_d     = 1'b0;
      to_half_d  = 1'b0;
    end else if (!i_stall) begin
      // Every unstalled cycle produces a fresh output; default is a bubble.
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      comp_d    = 1'b0;
      span_d    = 1'b0;
      to_half_d = 1'b0;
      unique case (state_q)
        StNormal: begin
          if (accept) begin
            if (parcel[1:0] != 2'b11) begin
              valid_d    = 1'b1;
              instr_d    = {16'h0000, parcel};
              instr_pc_d = pc_q;
              comp_d     = 1'b1;
              pc_d       = pc_q + XLEN'(2);
            end else if (!pc_q[1]) begin
              valid_d    = 1'b1;
              instr_d    = i_fetch_word;
              instr_pc_d = pc_q;
              pc_d       = pc_q + XLEN'(4);
            end else begin
              half_buf_d = parcel;
              state_d    = StSpanWait;
            end
          end
        end
        StSpanWait: begin
          if (accept) begin
            valid_d    = 1'b1;
            instr_d    = {i_fetch_word[15:0], half_buf_q};
            instr_pc_d = pc_q;
            span_d     = 1'b1;
            to_half_d  = 1'b1;
            pc_d       = pc_q + XLEN'(4);
            word_buf_d = i_fetch_word;
            state_d    = StSpanTail;
          end
        end
        StSpanTail: begin
          // Upper parcel of the word just consumed; no fetch needed.
          if (tail[1:0] != 2'b11) begin
            valid_d    = 1'b1;
            instr_d    = {16'h0000, tail};
            instr_pc_d = pc_q;
            comp_d     = 1'b1;
            pc_d       = pc_q + XLEN'(2);
            state_d    = StNormal;
          end else begin
            half_buf_d = tail;
            state_d    = StSpanWait;
          end
        end
        default: state_d = StNormal;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StNormal;
      pc_q       <= '0;
      half_buf_q <= '0;
      word_buf_q <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
      comp_q     <= 1'b0;
      span_q     <= 1'b0;
      to_half_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      half_buf_q <= half_buf_d;
      word_buf_q <= word_buf_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      comp_q     <= comp_d;
      span_q     <= span_d;
      to_half_q  <= to_half_d;
    end
  end

  assign o_instr_valid             = valid_q;
  assign o_instr                   = instr_q;
  assign o_instr_pc                = instr_pc_q;
  assign o_is_compressed           = comp_q;
  assign o_is_32bit_spanning       = span_q;
  assign o_spanning_to_halfword    = to_half_q;
  assign o_spanning_wait_for_fetch = (state_q == StSpanWait);
  assign o_spanning_in_progress    = (state_q != StNormal);

endmodule

// File: tb/tb_rvc_parcel_aligner.sv
// Scoreboard bench for rvc_parcel_aligner: directed words, expected instructions queued at
// issue time and checked by an independent output monitor.
module tb_rvc_parcel_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] rpc = '0;
  logic        stall = 1'b0;
  logic        fv = 1'b0;
  logic [31:0] w = '0;
  logic        fetch_ready, instr_valid, is_comp, is_span, wait_fetch, in_prog, to_half;
  logic [31:0] instr, instr_pc;

  rvc_parcel_aligner #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .i_flush                   (flush),
    .i_redirect_pc             (rpc),
    .i_stall                   (stall),
    .i_fetch_valid             (fv),
    .i_fetch_word              (w),
    .o_fetch_ready             (fetch_ready),
    .o_instr_valid             (instr_valid),
    .o_instr                   (instr),
    .o_instr_pc                (instr_pc),
    .o_is_compressed           (is_comp),
    .o_is_32bit_spanning       (is_span),
    .o_spanning_wait_for_fetch (wait_fetch),
    .o_spanning_in_progress    (in_prog),
    .o_spanning_to_halfword    (to_half)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        span;
    logic        toh;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic held_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void expect_out(input logic [31:0] i, input logic [31:0] p,
                                     input logic c, input logic s, input logic t);
    exp_t e;
    e.instr = i; e.pc = p; e.comp = c; e.span = s; e.toh = t;
    sb.push_back(e);
  endfunction

  // A stalled edge (without flush) holds the previous output; it is not a new instruction.
  always @(posedge clk) held_q <= stall && !flush;

  always @(negedge clk) begin
    if (!rst && instr_valid && !held_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", instr, 32'h0000_0013);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        chk("is_compressed", {31'b0, is_comp}, {31'b0, e.comp});
        chk("is_32bit_spanning", {31'b0, is_span}, {31'b0, e.span});
        chk("spanning_to_halfword", {31'b0, to_half}, {31'b0, e.toh});
      end
    end
  end

  task automatic cyc(input logic f, input logic [31:0] p, input logic st, input logic v,
                     input logic [31:0] word, input logic exp_ready);
    @(negedge clk);
    flush = f; rpc = p; stall = st; fv = v; w = word;
    #1 chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, exp_ready});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_flags", {27'b0, is_comp, is_span, wait_fetch, in_prog, to_half}, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs();

    // Enter SPAN_WAIT, then reset asynchronously mid-span.
    cyc(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0093_1234, 1'b1);
    after_edge();
    chk("wait_before_reset", {31'b0, wait_fetch}, 32'h1);
    @(negedge clk);
    fv = 1'b0;
    rst = 1'b1;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_outputs();

    // pc restarted at 0: aligned 32-bit word.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0093, 1'b1);
    expect_out(32'h00A0_0093, 32'h0, 1'b0, 1'b0, 1'b0);

    // Aligned 32-bit then two compressed parcels of one word.
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0093, 1'b1);
    expect_out(32'h00A0_0093, 32'h100, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0505_4501, 1'b1);
    expect_out(32'h0000_4501, 32'h104, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0505_4501, 1'b1);
    expect_out(32'h0000_0505, 32'h106, 1'b1, 1'b0, 1'b0);

    // Spanning instruction followed by a compressed tail.
    cyc(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0093_1234, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h4505_00A0, 1'b1);
    expect_out(32'h00A0_0093, 32'h102, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("tail_in_progress", {31'b0, in_prog}, 32'h1);
    expect_out(32'h0000_4505, 32'h106, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back spans: tail is the low half of another 32-bit instruction.
    cyc(1'b1, 32'h202, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0093_0000, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0113_00A0, 1'b1);
    expect_out(32'h00A0_0093, 32'h202, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    after_edge();
    chk("b2b_wait_fetch", {31'b0, wait_fetch}, 32'h1);
    chk("b2b_no_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h4505_0020, 1'b1);
    expect_out(32'h0020_0113, 32'h206, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_out(32'h0000_4505, 32'h20A, 1'b1, 1'b0, 1'b0);

    // Stall for three cycles with a word offered: nothing moves.
    cyc(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0093, 1'b1);
    expect_out(32'h00A0_0093, 32'h300, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0505_4501, 1'b0);
      chk("stall_instr", instr, 32'h00A0_0093);
      chk("stall_pc", instr_pc, 32'h300);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0505_4501, 1'b1);
    expect_out(32'h0000_4501, 32'h304, 1'b1, 1'b0, 1'b0);
    // Flush wins over stall.
    cyc(1'b1, 32'h401, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
    after_edge();
    chk("flush_in_stall_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h00A0_0093, 1'b1);
    expect_out(32'h00A0_0093, 32'h400, 1'b0, 1'b0, 1'b0);

    // Span across the top of the address space.
    cyc(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0093_0000, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h4505_00A0, 1'b1);
    expect_out(32'h00A0_0093, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    expect_out(32'h0000_4505, 32'h2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    repeat (3) @(negedge clk);
    #1 chk("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
